// File: rtl/axis_accum_pkg.sv
// Shared types and default widths for the multi-channel AXI-Stream accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   DATAW_DEF, SUMW_DEF, NUM_CH_DEF, CNTW_DEF : default parameter values
//   slot_state_e                              : output slot state (SLOT_EMPTY / SLOT_FULL)
//   accum_res_t                               : result record {id, sum, cnt, ovf} at the
//                                               widest supported ID and default widths
package axis_accum_pkg;

    localparam int DATAW_DEF  = 128;
    localparam int SUMW_DEF   = 128;
    localparam int NUM_CH_DEF = 4;
    localparam int CNTW_DEF   = 16;

    // Up to 16 channels, so 4 ID bits cover every legal configuration.
    localparam int IDW_MAX    = 4;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // One emitted result. Narrower builds zero-extend into this record.
    typedef struct packed {
        logic [IDW_MAX-1:0]  id;
        logic [SUMW_DEF-1:0] sum;
        logic [CNTW_DEF-1:0] cnt;
        logic                ovf;
    } accum_res_t;

endpackage

// File: rtl/accum_lane.sv
// Per-channel accumulator lane: running sum, beat counter and sticky overflow flag.
// Latency: state updates on the edge a beat is accepted; the final values are combinational.
// Backpressure: none here; the parent only pulses beat_i on an accepted beat for this lane.
//
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   beat_i         : accepted beat targets this lane this cycle
//   last_i         : that beat closes the transaction (lane clears instead of accumulating)
//   data_i         : unsigned addend
//   fin_sum_o/fin_cnt_o/fin_ovf_o : sum, count and overflow including the current beat
//
// Build option: ACCUM_SATURATE_EN clamps the sum to all-ones on carry-out instead of wrapping.
module accum_lane
    import axis_accum_pkg::*;
#(
    parameter int DATAW = DATAW_DEF,
    parameter int SUMW  = SUMW_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             beat_i,
    input  logic             last_i,
    input  logic [DATAW-1:0] data_i,
    output logic [SUMW-1:0]  fin_sum_o,
    output logic [CNTW-1:0]  fin_cnt_o,
    output logic             fin_ovf_o
);

    logic [SUMW-1:0] sum_q, sum_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic [SUMW:0]   add_full;
    logic            carry;
    logic [SUMW-1:0] add_sum;
    logic [CNTW-1:0] add_cnt;
    logic            add_ovf;

    always_comb begin
        // One extra bit on top of the sum captures the carry-out.
        add_full = {1'b0, sum_q} + {{(SUMW + 1 - DATAW){1'b0}}, data_i};
        carry    = add_full[SUMW];
`ifdef ACCUM_SATURATE_EN
        // Once clamped, any further non-zero addend carries again, so the
        // sum stays pinned at all-ones until the transaction closes.
        add_sum  = carry ? {SUMW{1'b1}} : add_full[SUMW-1:0];
`else
        add_sum  = add_full[SUMW-1:0];
`endif
        add_cnt  = cnt_q + CNTW'(1);
        add_ovf  = ovf_q | carry;
    end

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (beat_i) begin
            if (last_i) begin
                // Final totals leave through fin_*; start the next transaction clean.
                sum_d = '0;
                cnt_d = '0;
                ovf_d = 1'b0;
            end else begin
                sum_d = add_sum;
                cnt_d = add_cnt;
                ovf_d = add_ovf;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign fin_sum_o = add_sum;
    assign fin_cnt_o = add_cnt;
    assign fin_ovf_o = add_ovf;

endmodule

// File: rtl/axis_accum_mc.sv
// Multi-channel AXI-Stream accumulator: per-channel running sums, one result per TLAST beat.
// Latency: result valid on the cycle after its TLAST beat is accepted; 1 beat/cycle sustained.
// Backpressure: in_tready = rst && (slot empty || out_tready); out_* held while stalled.
//
// Ports:
//   clk, rst (async, active-low)
//   axis_accum_in_*  : slave beats {tvalid, tready, tlast, tid, tdata}; tid >= NUM_CH is dropped
//   axis_accum_out_* : master results {tvalid, tready, tid, tdata = sum, tuser = {ovf, cnt}}
//
// Build option: ACCUM_SATURATE_EN selects saturating sums (default: wrap-around, sticky ovf).
module axis_accum_mc
    import axis_accum_pkg::*;
#(
    parameter int DATAW  = DATAW_DEF,
    parameter int SUMW   = SUMW_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int IDW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axis_accum_in_tvalid,
    output logic             axis_accum_in_tready,
    input  logic             axis_accum_in_tlast,
    input  logic [IDW-1:0]   axis_accum_in_tid,
    input  logic [DATAW-1:0] axis_accum_in_tdata,
    output logic             axis_accum_out_tvalid,
    input  logic             axis_accum_out_tready,
    output logic [IDW-1:0]   axis_accum_out_tid,
    output logic [SUMW-1:0]  axis_accum_out_tdata,
    output logic [CNTW:0]    axis_accum_out_tuser
);

    // One extra bit so the compare also works when NUM_CH == 2**IDW.
    localparam logic [IDW:0] NUM_CH_W = (IDW + 1)'(NUM_CH);

    // ------------------------------------------------------------------
    // Input handshake and ID decode
    // ------------------------------------------------------------------
    logic              in_acc;
    logic              id_ok;
    logic              load;
    logic              drain;
    logic [NUM_CH-1:0] lane_beat;

    assign in_acc = axis_accum_in_tvalid && axis_accum_in_tready;
    assign id_ok  = ({1'b0, axis_accum_in_tid} < NUM_CH_W);
    assign load   = in_acc && id_ok && axis_accum_in_tlast;
    assign drain  = axis_accum_out_tvalid && axis_accum_out_tready;

    // ------------------------------------------------------------------
    // Channel lanes
    // ------------------------------------------------------------------
    logic [SUMW-1:0] lane_sum [NUM_CH];
    logic [CNTW-1:0] lane_cnt [NUM_CH];
    logic            lane_ovf [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        assign lane_beat[c] = in_acc && id_ok && (axis_accum_in_tid == IDW'(c));

        accum_lane #(
            .DATAW (DATAW),
            .SUMW  (SUMW),
            .CNTW  (CNTW)
        ) u_lane (
            .clk_i     (clk),
            .rst_n_i   (rst),
            .beat_i    (lane_beat[c]),
            .last_i    (axis_accum_in_tlast),
            .data_i    (axis_accum_in_tdata),
            .fin_sum_o (lane_sum[c]),
            .fin_cnt_o (lane_cnt[c]),
            .fin_ovf_o (lane_ovf[c])
        );
    end

    // Select the addressed lane's final values. A compare-and-or mux keeps
    // out-of-range IDs from indexing past the lane array.
    logic [SUMW-1:0] sel_sum;
    logic [CNTW-1:0] sel_cnt;
    logic            sel_ovf;

    always_comb begin
        sel_sum = '0;
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (axis_accum_in_tid == IDW'(c)) begin
                sel_sum = lane_sum[c];
                sel_cnt = lane_cnt[c];
                sel_ovf = lane_ovf[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output slot FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    slot_state_e slot_q, slot_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            SLOT_EMPTY: begin
                if (load) begin
                    slot_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                // A load while full can only happen when out_tready is high,
                // i.e. the old result drains on the same edge.
                if (load) begin
                    slot_d = SLOT_FULL;
                end else if (drain) begin
                    slot_d = SLOT_EMPTY;
                end
            end
            default: slot_d = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        axis_accum_out_tvalid = (slot_q == SLOT_FULL);
        // Non-last beats also stall on a blocked slot so the ready term stays
        // a single expression independent of tlast and tid.
        axis_accum_in_tready  = rst && ((slot_q == SLOT_EMPTY) || axis_accum_out_tready);
    end

    // ------------------------------------------------------------------
    // Output slot payload
    // ------------------------------------------------------------------
    logic [IDW-1:0]  out_tid_q, out_tid_d;
    logic [SUMW-1:0] out_sum_q, out_sum_d;
    logic [CNTW-1:0] out_cnt_q, out_cnt_d;
    logic            out_ovf_q, out_ovf_d;

    always_comb begin
        out_tid_d = out_tid_q;
        out_sum_d = out_sum_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;
        if (load) begin
            out_tid_d = axis_accum_in_tid;
            out_sum_d = sel_sum;
            out_cnt_d = sel_cnt;
            out_ovf_d = sel_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_tid_q <= '0;
            out_sum_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            out_tid_q <= out_tid_d;
            out_sum_q <= out_sum_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign axis_accum_out_tid   = out_tid_q;
    assign axis_accum_out_tdata = out_sum_q;
    assign axis_accum_out_tuser = {out_ovf_q, out_cnt_q};

endmodule
